tmec_chien_serial: RTL and testbench
====================================

TMEC_CHIEN_SERIAL -- requirements
Module: tmec_chien_serial

Interface
REQ-001 SHALL have parameter M, default 4: GF(2^M) symbol width.
REQ-002 SHALL have parameter T, default 3: correctable errors; locator degree limit.
REQ-003 SHALL have parameter DATA_BITS, default 5: data bits output per codeword.
REQ-004 SHALL have parameter ECC_BITS, default M*T: parity bits; codeword length L = DATA_BITS+ECC_BITS, L <= N = 2^M-1.
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port start, input, 1: load request for a new locator.
REQ-008 SHALL have port cNin, input, M*(T+1): locator coefficients c0..cT, standard basis, ci at [i*M+:M].
REQ-009 SHALL have port busy, output, 1: evaluation in progress.
REQ-010 SHALL have port valid, output, 1: err/first/last are meaningful this cycle.
REQ-011 SHALL have port ready, input, 1: consumer accepts the current bit.
REQ-012 SHALL have port err, output, 1: error flag for the current data bit.
REQ-013 SHALL have port first, output, 1: current bit is data position 0.
REQ-014 SHALL have port last, output, 1: current bit is data position DATA_BITS-1.
REQ-015 SHALL have port err_count, output, clog2(T+1)+1: errors flagged so far in this codeword, saturating.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> IDLE, with busy = (state==RUN).
REQ-017 SHALL, in IDLE with start=1, load term register i with ci*alpha^(i*(N-L+1)), clear the position counter and err_count, and enter RUN next cycle.
REQ-018 SHALL ignore start while in RUN; cNin SHALL NOT be sampled then.
REQ-019 SHALL, in RUN, drive valid=1 and err = (XOR of all T+1 term registers == 0).
REQ-020 SHALL make data position j flagged iff sigma(alpha^(N-(L-1-j))) = 0, i.e. a root at codeword degree L-1-j.
REQ-021 SHALL, on valid&&ready, multiply term i by constant alpha^i (term 0 unchanged), increment the position counter, and increment err_count if err=1.
REQ-022 SHALL hold all term, counter and output state unchanged when valid&&!ready.
REQ-023 SHALL assert first when counter==0 and last when counter==DATA_BITS-1.
REQ-024 SHALL return to IDLE on the cycle after the handshake that consumes the last bit; start may load on that IDLE cycle (one idle bubble between codewords).
REQ-025 SHALL hold err_count after completion until the next load.
REQ-026 SHALL saturate err_count at its maximum representable value.
REQ-027 SHALL make latency from start accepted to first valid exactly 1 cycle.
REQ-028 SHALL flag, for c0=0, positions with sum==0 unchanged; no special case is made.

Reset
REQ-029 SHALL, on reset, drive state=IDLE, busy=0, valid=0, err=0, first=0, last=0, err_count=0, with term registers and counter cleared.
REQ-030 SHALL abort a run when reset asserts mid-run and ignore start in the same cycle.

Structure
REQ-031 SHALL obtain alpha-power constants, constant-multiplier matrix generation and primitive polynomial lookup from the shared bch.vh function include.
REQ-032 SHALL use one sub-module, tmec_chien_term (parameters M, power): a load/step register with constant GF multiplier, instantiated T+1 times in a generate loop.
REQ-033 SHALL use the codebase primitive polynomial, x^4+x+1 for M=4.

Verification (M=4, T=2, DATA_BITS=7, ECC_BITS=8, L=15)
REQ-034 SHALL verify: cNin c0=1, c1=0, c2=0, start, ready=1 -> 7 valid beats, err all 0, first on beat 0, last on beat 6, err_count=0.
REQ-035 SHALL verify: c0=1, c1=4'hE (alpha^11), c2=0 -> err=1 only on beat 3, err_count=1.
REQ-036 SHALL verify: same load as REQ-035 with ready low on beats 2-4 for 3 cycles each -> beat sequence unchanged, err on beat 3 only, valid held high during stalls.
REQ-037 SHALL verify: start pulsed with a different cNin during RUN -> ignored, output matches the original locator.
REQ-038 SHALL verify: reset at beat 4 -> next cycle all outputs 0, IDLE; a subsequent start loads and runs normally.
REQ-039 SHALL verify: back-to-back codewords, start held high -> second run begins exactly 1 idle cycle after the first run's last handshake.

Source files
------------

// File: rtl/tmec_chien_serial_pkg.sv
// Shared GF(2^m) helpers for the serial Chien search: primitive polynomials,
// alpha powers and constant-multiplier matrices evaluated at elaboration time.
package tmec_chien_serial_pkg;

   localparam int GF_MAX_M = 16;
   localparam int GF_MAT_W = GF_MAX_M * GF_MAX_M;

   typedef logic [31:0]         gf_word_t;
   typedef logic [GF_MAT_W-1:0] gf_matrix_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chien_state_e;

   // Polynomials include the x^m term so a single XOR reduces an overflowed shift.
   function automatic gf_word_t gf_prim_poly(input int m);
      gf_word_t p;
      case (m)
         2:       p = 32'h0000_0007;
         3:       p = 32'h0000_000B;
         4:       p = 32'h0000_0013;
         5:       p = 32'h0000_0025;
         6:       p = 32'h0000_0043;
         7:       p = 32'h0000_0089;
         8:       p = 32'h0000_011D;
         9:       p = 32'h0000_0211;
         10:      p = 32'h0000_0409;
         11:      p = 32'h0000_0805;
         12:      p = 32'h0000_1053;
         13:      p = 32'h0000_201B;
         14:      p = 32'h0000_4443;
         15:      p = 32'h0000_8003;
         16:      p = 32'h0001_100B;
         default: p = 32'h0000_0013;
      endcase
      return p;
   endfunction

   function automatic gf_word_t gf_mul_alpha(input gf_word_t a, input int m);
      gf_word_t s;
      s = a << 1;
      if (s[m]) begin
         s = s ^ gf_prim_poly(m);
      end
      return s;
   endfunction

   function automatic gf_word_t gf_alpha_pow(input int e, input int m);
      gf_word_t r;
      int       n;
      n = (1 << m) - 1;
      r = 32'd1;
      for (int k = 0; k < (e % n); k++) begin
         r = gf_mul_alpha(r, m);
      end
      return r;
   endfunction

   // Column j holds alpha^e * alpha^j, the image of basis vector x^j.
   function automatic gf_matrix_t gf_const_matrix(input int e, input int m);
      gf_matrix_t mat;
      gf_word_t   col;
      mat = '0;
      col = gf_alpha_pow(e, m);
      for (int j = 0; j < GF_MAX_M; j++) begin
         if (j < m) begin
            mat[j*GF_MAX_M +: GF_MAX_M] = col[GF_MAX_M-1:0];
            col = gf_mul_alpha(col, m);
         end
      end
      return mat;
   endfunction

endpackage

// File: rtl/tmec_chien_term.sv
// One Chien term register: loads a scaled coefficient, then multiplies itself
// by the constant alpha^POWER on every step.
module tmec_chien_term
   import tmec_chien_serial_pkg::*;
#(
   parameter int M     = 4,
   parameter int POWER = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         step,
   input  logic [M-1:0] load_val,
   output logic [M-1:0] term
);

   localparam int         N        = (1 << M) - 1;
   localparam gf_matrix_t STEP_MAT = gf_const_matrix(POWER % N, M);

   logic [M-1:0] term_q;
   logic [M-1:0] term_d;
   logic [M-1:0] step_val;

   always_comb begin
      step_val = '0;
      for (int r = 0; r < M; r++) begin
         for (int j = 0; j < M; j++) begin
            if (STEP_MAT[j*GF_MAX_M + r]) begin
               step_val[r] = step_val[r] ^ term_q[j];
            end
         end
      end
   end

   always_comb begin
      term_d = term_q;
      if (load) begin
         term_d = load_val;
      end else if (step) begin
         term_d = step_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         term_q <= '0;
      end else begin
         term_q <= term_d;
      end
   end

   assign term = term_q;

endmodule

// File: rtl/tmec_chien_serial.sv
// Serial Chien search: evaluates the error locator at one data position per
// accepted beat and flags roots, with a ready/valid output handshake.
module tmec_chien_serial
   import tmec_chien_serial_pkg::*;
#(
   parameter int M         = 4,
   parameter int T         = 3,
   parameter int DATA_BITS = 5,
   parameter int ECC_BITS  = M * T
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [M*(T+1)-1:0]     cNin,
   output logic                   busy,
   output logic                   valid,
   input  logic                   ready,
   output logic                   err,
   output logic                   first,
   output logic                   last,
   output logic [$clog2(T+1):0]   err_count
);

   localparam int N     = (1 << M) - 1;
   localparam int L     = DATA_BITS + ECC_BITS;
   localparam int SHIFT = N - L + 1;
   localparam int CNT_W = $clog2(DATA_BITS + 1);
   localparam int EC_W  = $clog2(T + 1) + 1;

   localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA_BITS - 1);
   localparam logic [EC_W-1:0]  EC_MAX   = '1;

   chien_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EC_W-1:0]  ec_q, ec_d;
   logic             load;
   logic             step;
   logic             running;
   logic             root;
   logic [M-1:0]     term [T+1];
   logic [M-1:0]     term_sum;

   // Loading term i with ci*alpha^(i*SHIFT) aligns beat 0 with codeword degree L-1.
   for (genvar gi = 0; gi <= T; gi++) begin : g_term
      localparam gf_matrix_t LOAD_MAT = gf_const_matrix((gi * SHIFT) % N, M);
      logic [M-1:0] load_val;

      always_comb begin
         load_val = '0;
         for (int r = 0; r < M; r++) begin
            for (int j = 0; j < M; j++) begin
               if (LOAD_MAT[j*GF_MAX_M + r]) begin
                  load_val[r] = load_val[r] ^ cNin[gi*M + j];
               end
            end
         end
      end

      tmec_chien_term #(
         .M     (M),
         .POWER (gi)
      ) u_term (
         .clk      (clk),
         .reset    (reset),
         .load     (load),
         .step     (step),
         .load_val (load_val),
         .term     (term[gi])
      );
   end

   always_comb begin
      term_sum = '0;
      for (int i = 0; i <= T; i++) begin
         term_sum = term_sum ^ term[i];
      end
   end

   assign running = (state_q == ST_RUN);
   assign root    = (term_sum == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ec_d    = ec_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               cnt_d   = '0;
               ec_d    = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ready) begin
               step  = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (root && (ec_q != EC_MAX)) begin
                  ec_d = ec_q + EC_W'(1);
               end
               if (cnt_q == LAST_POS) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ec_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ec_q    <= ec_d;
      end
   end

   assign busy      = running;
   assign valid     = running;
   assign err       = running && root;
   assign first     = running && (cnt_q == '0);
   assign last      = running && (cnt_q == LAST_POS);
   assign err_count = ec_q;

endmodule

// File: tb/tb_tmec_chien_serial.sv
// Directed bench for the serial Chien search with M=4, T=2, 7 data bits, L=15.
module tb_tmec_chien_serial;

   localparam int M         = 4;
   localparam int T         = 2;
   localparam int DATA_BITS = 7;
   localparam int ECC_BITS  = 8;
   localparam int EC_W      = $clog2(T + 1) + 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic                 ready;
   logic [M*(T+1)-1:0]   cNin;
   logic                 busy;
   logic                 valid;
   logic                 err;
   logic                 first;
   logic                 last;
   logic [EC_W-1:0]      err_count;

   int checkCount = 0;
   int errorCount = 0;

   tmec_chien_serial #(
      .M         (M),
      .T         (T),
      .DATA_BITS (DATA_BITS),
      .ECC_BITS  (ECC_BITS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cNin      (cNin),
      .busy      (busy),
      .valid     (valid),
      .ready     (ready),
      .err       (err),
      .first     (first),
      .last      (last),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [M*(T+1)-1:0] c, input logic r);
      start = s;
      cNin  = c;
      ready = r;
   endtask

   task automatic checkIdle(input string tag, input int expCount);
      checkOutput({tag, " busy"},  32'(busy),  32'd0);
      checkOutput({tag, " valid"}, 32'(valid), 32'd0);
      checkOutput({tag, " err"},   32'(err),   32'd0);
      checkOutput({tag, " first"}, 32'(first), 32'd0);
      checkOutput({tag, " last"},  32'(last),  32'd0);
      checkOutput({tag, " count"}, 32'(err_count), 32'(expCount));
   endtask

   task automatic checkBeat(input int testId, input int b, input logic expErr, input int expCount);
      string tag;
      tag = $sformatf("t%0d beat%0d", testId, b);
      checkOutput({tag, " valid"}, 32'(valid), 32'd1);
      checkOutput({tag, " busy"},  32'(busy),  32'd1);
      checkOutput({tag, " err"},   32'(err),   32'(expErr));
      checkOutput({tag, " first"}, 32'(first), 32'(b == 0));
      checkOutput({tag, " last"},  32'(last),  32'(b == DATA_BITS - 1));
      checkOutput({tag, " count"}, 32'(err_count), 32'(expCount));
   endtask

   task automatic loadLocator(input logic [M*(T+1)-1:0] loc);
      applyStimulus(1'b1, loc, 1'b1);
      @(negedge clk);
   endtask

   // Walks numBeats beats; stalled beats hold ready low for 3 cycles first.
   task automatic consumeBeats(input int testId, input logic [M*(T+1)-1:0] loc,
                               input logic [6:0] expMask, input logic [6:0] stallMask,
                               input int pulseBeat, input int numBeats, input logic holdStart);
      int seen;
      seen = 0;
      for (int b = 0; b < numBeats; b++) begin
         if (stallMask[b]) begin
            for (int s = 0; s < 3; s++) begin
               applyStimulus(holdStart, loc, 1'b0);
               checkBeat(testId, b, expMask[b], seen);
               @(negedge clk);
            end
         end
         checkBeat(testId, b, expMask[b], seen);
         if (b == pulseBeat) begin
            applyStimulus(1'b1, ~loc, 1'b1);
         end else begin
            applyStimulus(holdStart, loc, 1'b1);
         end
         if (expMask[b]) begin
            seen++;
         end
         @(negedge clk);
      end
      if (numBeats == DATA_BITS) begin
         checkOutput($sformatf("t%0d done busy", testId),  32'(busy),  32'd0);
         checkOutput($sformatf("t%0d done valid", testId), 32'(valid), 32'd0);
         checkOutput($sformatf("t%0d done count", testId), 32'(err_count), 32'(seen));
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkIdle("reset", 0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] sigma = 1: no roots");
      loadLocator(12'h001);
      consumeBeats(1, 12'h001, 7'b0000000, 7'b0000000, -1, DATA_BITS, 1'b0);

      $display("[TB] sigma = 1 + a^11 x: root on beat 3");
      loadLocator(12'h0E1);
      consumeBeats(2, 12'h0E1, 7'b0001000, 7'b0000000, -1, DATA_BITS, 1'b0);

      $display("[TB] stalls on beats 2-4");
      loadLocator(12'h0E1);
      consumeBeats(3, 12'h0E1, 7'b0001000, 7'b0011100, -1, DATA_BITS, 1'b0);

      $display("[TB] start pulse during run is ignored");
      loadLocator(12'h0E1);
      consumeBeats(4, 12'h0E1, 7'b0001000, 7'b0000000, 1, DATA_BITS, 1'b0);

      $display("[TB] all-zero locator flags every bit");
      loadLocator(12'h000);
      consumeBeats(5, 12'h000, 7'b1111111, 7'b0000000, -1, DATA_BITS, 1'b0);

      $display("[TB] reset at beat 4");
      loadLocator(12'h0E1);
      consumeBeats(6, 12'h0E1, 7'b0001000, 7'b0000000, -1, 4, 1'b0);
      checkBeat(6, 4, 1'b0, 1);
      reset = 1'b1;
      applyStimulus(1'b1, 12'h531, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 12'h531, 1'b0);
      checkIdle("t6 after reset", 0);

      $display("[TB] two roots after reset: beats 0 and 5");
      loadLocator(12'h531);
      consumeBeats(7, 12'h531, 7'b0100001, 7'b0000000, -1, DATA_BITS, 1'b0);

      $display("[TB] back-to-back with start held");
      loadLocator(12'h0E1);
      consumeBeats(8, 12'h0E1, 7'b0001000, 7'b0000000, -1, DATA_BITS, 1'b1);
      applyStimulus(1'b1, 12'h531, 1'b1);
      @(negedge clk);
      consumeBeats(9, 12'h531, 7'b0100001, 7'b0000000, -1, DATA_BITS, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
